mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter and access sequencer for the single 12-bit-address / 16-bit-data program/data memory.
- Shares the memory between the CPU core's rd/wr port and a DMA/loader port.
- Round-robin grant on contention; one request serviced at a time.
- Each access is stretched by a programmable number of wait states before a one-cycle ack returns to the winning requester.

Parameters:
- AW, 12, address width
- DW, 16, data width
- WAIT_STATES, 1, extra memory cycles per access (legal 0..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  AW  CPU address
- cpu_wdata  input  DW  CPU write data
- cpu_rdata  output  DW  read data returned to CPU
- cpu_ack  output  1  one-cycle completion pulse to CPU
- dma_req  input  1  DMA access request, held until dma_ack
- dma_we  input  1  1 = write, 0 = read
- dma_addr  input  AW  DMA address
- dma_wdata  input  DW  DMA write data
- dma_rdata  output  DW  read data returned to DMA
- dma_ack  output  1  one-cycle completion pulse to DMA
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_rdata  input  DW  memory read data
- grant  output  2  one-hot current owner: [0] = CPU, [1] = DMA; 00 when idle
- busy  output  1  high in ACCESS or DONE

Behaviour:
- All state and outputs are registered.
- Reset (rst low, asynchronous): state=IDLE, last_grant=DMA, wait counter=0. All outputs 0, including both rdata registers.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the master that is not last_grant; CPU wins the first tie after reset.
  - On the grant edge: latch the winner's addr/we/wdata, set grant, set last_grant, load counter=WAIT_STATES, go to ACCESS.
- ACCESS:
  - Drive mem_addr=latched addr.
  - Read: mem_rd=1. Write: mem_wr=1, mem_wdata=latched wdata.
  - Counter decrements each cycle; when counter==0, go to DONE.
  - A read captures mem_rdata into the owner's rdata register on that final edge.
  - ACCESS lasts WAIT_STATES+1 cycles.
- DONE:
  - Owner's ack=1 for exactly one cycle; strobes low; mem_addr/mem_wdata=0.
  - Next state: IDLE; grant clears on that edge.
- Outside ACCESS: mem_addr, mem_wdata, mem_rd and mem_wr are 0.
- Latency: a request seen in IDLE at cycle 0 produces ack in cycle WAIT_STATES+2. Default is 3 cycles.
- Throughput: minimum 3+WAIT_STATES cycles per access, because IDLE always takes one cycle.
- rdata registers:
  - Update only on that port's own reads; hold across writes and across the other port's accesses.
  - Valid from the ack cycle until the port's next read completes.
- Requester rule: the requester changes req/addr/we/wdata only on the edge where it samples ack=1. If req is still high in the following IDLE, it is a new request and is arbitrated normally.
- Request dropped mid-access: the access still completes, ack still pulses, and the arbiter ignores the drop. Inputs changing after the grant have no effect, because they were latched.
- Simultaneous requests every time: strict alternation CPU, DMA, CPU, ...
- Single requester repeating: it is served back-to-back; last_grant does not block it.
- Reset asserted mid-ACCESS or mid-DONE: strobes and ack drop immediately (asynchronously). The access is abandoned with no ack after reset release.
- Exactly one of mem_rd/mem_wr is high, and only in ACCESS. cpu_ack and dma_ack are never high together.

Test Plan:
- Reset then idle: rst low → all outputs 0. Release with no req → grant=00, busy=0 for 10 cycles.
- CPU read, WAIT_STATES=1: cpu_req=1, cpu_we=0, cpu_addr=12'h0A5; memory returns 16'h1234 → mem_rd high 2 cycles with mem_addr=0A5; cpu_ack in cycle 3; cpu_rdata=1234 and held afterwards.
- DMA write: dma_we=1, dma_addr=12'hFFF, dma_wdata=16'hBEEF → mem_wr high 2 cycles with addr FFF and data BEEF; dma_ack one cycle; cpu_rdata unchanged.
- Contention: both masters request continuously for 6 accesses → grant order CPU, DMA, CPU, DMA, CPU, DMA; acks never overlap.
- WAIT_STATES=0 and WAIT_STATES=15 builds: ACCESS lasts 1 / 16 cycles; ack arrives at cycle 2 / 17.
- Reset mid-access: assert rst in the 2nd ACCESS cycle → mem_rd=0 at once; no ack after release; a following CPU read works normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (CPU / DMA) arbiter and access sequencer for the shared program/data memory.
// Round-robin grant on contention, programmable wait states, one-cycle ack to the winner.
module mem_arbiter #(
    parameter int AW          = 12,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_n;
    logic          last_dma, last_dma_n;
    logic [3:0]    cnt, cnt_n;
    logic          cpu_win, dma_win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [DW-1:0] cpu_rdata_n, dma_rdata_n, mem_wdata_n;
    logic [AW-1:0] mem_addr_n;
    logic          cpu_ack_n, dma_ack_n, mem_rd_n, mem_wr_n, busy_n;
    logic [1:0]    grant_n;

    // The memory outputs themselves hold the latched request for the whole ACCESS phase.
    always_comb begin
        state_n     = state;
        last_dma_n  = last_dma;
        cnt_n       = cnt;
        cpu_rdata_n = cpu_rdata;
        dma_rdata_n = dma_rdata;
        cpu_ack_n   = 1'b0;
        dma_ack_n   = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_rd_n    = mem_rd;
        mem_wr_n    = mem_wr;
        grant_n     = grant;
        busy_n      = busy;

        cpu_win   = cpu_req & (~dma_req | last_dma);
        dma_win   = dma_req & ~cpu_win;
        sel_we    = cpu_win ? cpu_we    : dma_we;
        sel_addr  = cpu_win ? cpu_addr  : dma_addr;
        sel_wdata = cpu_win ? cpu_wdata : dma_wdata;

        case (state)
            IDLE: begin
                if (cpu_win | dma_win) begin
                    state_n     = ACCESS;
                    grant_n     = {dma_win, cpu_win};
                    last_dma_n  = dma_win;
                    cnt_n       = 4'(WAIT_STATES);
                    busy_n      = 1'b1;
                    mem_addr_n  = sel_addr;
                    mem_rd_n    = ~sel_we;
                    mem_wr_n    = sel_we;
                    mem_wdata_n = sel_we ? sel_wdata : '0;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_n     = DONE;
                    cpu_ack_n   = grant[0];
                    dma_ack_n   = grant[1];
                    mem_addr_n  = '0;
                    mem_wdata_n = '0;
                    mem_rd_n    = 1'b0;
                    mem_wr_n    = 1'b0;
                    if (mem_rd && grant[0]) cpu_rdata_n = mem_rdata;
                    if (mem_rd && grant[1]) dma_rdata_n = mem_rdata;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = 2'b00;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                grant_n = 2'b00;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_dma  <= 1'b1;
            cnt       <= 4'd0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            last_dma  <= last_dma_n;
            cnt       <= cnt_n;
            cpu_rdata <= cpu_rdata_n;
            dma_rdata <= dma_rdata_n;
            cpu_ack   <= cpu_ack_n;
            dma_ack   <= dma_ack_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_rd    <= mem_rd_n;
            mem_wr    <= mem_wr_n;
            grant     <= grant_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: default build plus WAIT_STATES=0 and 15 builds.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [11:0] cpu_addr = '0, dma_addr = '0;
    logic [15:0] cpu_wdata = '0, dma_wdata = '0;
    logic [15:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, dma_ack, mem_rd, mem_wr, busy;
    logic [11:0] mem_addr;
    logic [1:0]  grant;
    logic        rd_fixed_en = 1'b1;
    logic [15:0] rd_fixed = '0;

    // Memory model: either a fixed word or a pattern derived from the address.
    assign mem_rdata = rd_fixed_en ? rd_fixed : {4'hA, mem_addr};

    always #5 clk = ~clk;

    mem_arbiter #(.AW(12), .DW(16), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    logic        p0_req = 0, p15_req = 0;
    logic        x_zero = 1'b0;
    logic [11:0] x_addr = 12'h100, x_zaddr = '0;
    logic [15:0] x_zdata = '0, x_rdata = 16'h5A5A;
    logic [15:0] p0_cpu_rdata, p0_dma_rdata, p0_mem_wdata, p15_cpu_rdata, p15_dma_rdata, p15_mem_wdata;
    logic [11:0] p0_mem_addr, p15_mem_addr;
    logic        p0_cpu_ack, p0_dma_ack, p0_mem_rd, p0_mem_wr, p0_busy;
    logic        p15_cpu_ack, p15_dma_ack, p15_mem_rd, p15_mem_wr, p15_busy;
    logic [1:0]  p0_grant, p15_grant;

    mem_arbiter #(.AW(12), .DW(16), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .cpu_req(p0_req), .cpu_we(x_zero), .cpu_addr(x_addr), .cpu_wdata(x_zdata),
        .cpu_rdata(p0_cpu_rdata), .cpu_ack(p0_cpu_ack),
        .dma_req(x_zero), .dma_we(x_zero), .dma_addr(x_zaddr), .dma_wdata(x_zdata),
        .dma_rdata(p0_dma_rdata), .dma_ack(p0_dma_ack),
        .mem_addr(p0_mem_addr), .mem_wdata(p0_mem_wdata), .mem_rd(p0_mem_rd), .mem_wr(p0_mem_wr),
        .mem_rdata(x_rdata), .grant(p0_grant), .busy(p0_busy)
    );

    mem_arbiter #(.AW(12), .DW(16), .WAIT_STATES(15)) u_ws15 (
        .clk(clk), .rst(rst),
        .cpu_req(p15_req), .cpu_we(x_zero), .cpu_addr(x_addr), .cpu_wdata(x_zdata),
        .cpu_rdata(p15_cpu_rdata), .cpu_ack(p15_cpu_ack),
        .dma_req(x_zero), .dma_we(x_zero), .dma_addr(x_zaddr), .dma_wdata(x_zdata),
        .dma_rdata(p15_dma_rdata), .dma_ack(p15_dma_ack),
        .mem_addr(p15_mem_addr), .mem_wdata(p15_mem_wdata), .mem_rd(p15_mem_rd), .mem_wr(p15_mem_wr),
        .mem_rdata(x_rdata), .grant(p15_grant), .busy(p15_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({cpu_rdata, cpu_ack, dma_rdata, dma_ack, mem_addr, mem_wdata, mem_rd, mem_wr, grant, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cpu_rdata=%h dma_rdata=%h mem_addr=%h grant=%b busy=%b required all zero",
                     cpu_rdata, dma_rdata, mem_addr, grant, busy);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({grant, busy} !== 3'b000) begin
                failures++;
                $display("FAIL idle_after_reset cycle=%0d got grant=%b busy=%b required 00/0", i, grant, busy);
            end
        end
    endtask

    task automatic test_cpu_read();
        rd_fixed_en = 1'b1;
        rd_fixed    = 16'h1234;
        cpu_we      = 1'b0;
        cpu_addr    = 12'h0A5;
        cpu_req     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack} !== ((c <= 2) ? 4'b1000 : 4'b0010)) begin
                failures++;
                $display("FAIL cpu_read_strobes cycle=%0d got rd/wr/cack/dack=%b%b%b%b", c, mem_rd, mem_wr, cpu_ack, dma_ack);
            end
            checks++;
            if (mem_addr !== ((c <= 2) ? 12'h0A5 : 12'h000) || grant !== 2'b01) begin
                failures++;
                $display("FAIL cpu_read_addr cycle=%0d got addr=%h grant=%b required addr=%h grant=01",
                         c, mem_addr, grant, (c <= 2) ? 12'h0A5 : 12'h000);
            end
        end
        checks++;
        if (cpu_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL cpu_read_data got=%h required=1234", cpu_rdata);
        end
        cpu_req  = 1'b0;
        rd_fixed = 16'h0000;
        tick();
        tick();
        checks++;
        if (cpu_rdata !== 16'h1234 || grant !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_hold got rdata=%h grant=%b busy=%b required 1234/00/0", cpu_rdata, grant, busy);
        end
    endtask

    task automatic test_dma_write();
        dma_we    = 1'b1;
        dma_addr  = 12'hFFF;
        dma_wdata = 16'hBEEF;
        dma_req   = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack} !== ((c <= 2) ? 4'b0100 : 4'b0001)) begin
                failures++;
                $display("FAIL dma_write_strobes cycle=%0d got rd/wr/cack/dack=%b%b%b%b", c, mem_rd, mem_wr, cpu_ack, dma_ack);
            end
            checks++;
            if (mem_addr !== ((c <= 2) ? 12'hFFF : 12'h000) || mem_wdata !== ((c <= 2) ? 16'hBEEF : 16'h0000)
                || grant !== 2'b10) begin
                failures++;
                $display("FAIL dma_write_bus cycle=%0d got addr=%h wdata=%h grant=%b", c, mem_addr, mem_wdata, grant);
            end
        end
        dma_req = 1'b0;
        checks++;
        if (cpu_rdata !== 16'h1234 || dma_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL dma_write_rdata got cpu_rdata=%h dma_rdata=%h required 1234/0000", cpu_rdata, dma_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic found;
        rd_fixed_en = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 12'h011;
        dma_we   = 1'b0;
        dma_addr = 12'h022;
        cpu_req  = 1'b1;
        dma_req  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            for (int n = 0; n < 10 && !found; n++) begin
                tick();
                if (grant !== 2'b00) found = 1'b1;
            end
            checks++;
            if (!found || grant !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL contention_grant access=%0d got=%b required=%b", k, grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            found = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                tick();
                checks++;
                if (cpu_ack && dma_ack) begin
                    failures++;
                    $display("FAIL contention_ack_overlap access=%0d got both acks high required at most one", k);
                end
                if (cpu_ack || dma_ack) found = 1'b1;
            end
            checks++;
            if ({cpu_ack, dma_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_ack access=%0d got cpu/dma=%b%b", k, cpu_ack, dma_ack);
            end
            checks++;
            if ((k % 2 == 0) ? (cpu_rdata !== 16'hA011) : (dma_rdata !== 16'hA022)) begin
                failures++;
                $display("FAIL contention_rdata access=%0d got cpu=%h dma=%h required cpu=A011/dma=A022",
                         k, cpu_rdata, dma_rdata);
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        rd_fixed_en = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 12'h033;
        cpu_req  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            checks++;
            if (cpu_ack !== ((c == 3) || (c == 7))) begin
                failures++;
                $display("FAIL b2b_ack cycle=%0d got=%b required=%b", c, cpu_ack, (c == 3) || (c == 7));
            end
            if (c == 5) begin
                checks++;
                if (grant !== 2'b01 || mem_addr !== 12'h033) begin
                    failures++;
                    $display("FAIL b2b_regrant got grant=%b addr=%h required 01/033", grant, mem_addr);
                end
                cpu_req  = 1'b0;
                cpu_addr = 12'h3FF;
            end
            if (c == 6) begin
                checks++;
                if (mem_addr !== 12'h033 || mem_rd !== 1'b1) begin
                    failures++;
                    $display("FAIL drop_latched got addr=%h rd=%b required 033/1", mem_addr, mem_rd);
                end
            end
        end
        checks++;
        if (cpu_rdata !== 16'hA033) begin
            failures++;
            $display("FAIL b2b_rdata got=%h required=A033", cpu_rdata);
        end
        tick();
        tick();
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle got grant=%b busy=%b required 00/0", grant, busy);
        end
    endtask

    task automatic test_wait_states();
        int rd0 = 0, rd15 = 0, ack0 = 0, ack15 = 0;
        p0_req  = 1'b1;
        p15_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (p0_mem_rd) rd0++;
            if (p15_mem_rd) rd15++;
            if (p0_cpu_ack && ack0 == 0) begin
                ack0   = c;
                p0_req = 1'b0;
            end
            if (p15_cpu_ack && ack15 == 0) begin
                ack15   = c;
                p15_req = 1'b0;
            end
        end
        checks++;
        if (rd0 != 1 || ack0 != 2) begin
            failures++;
            $display("FAIL ws0_timing got access_cycles=%0d ack_cycle=%0d required 1/2", rd0, ack0);
        end
        checks++;
        if (rd15 != 16 || ack15 != 17) begin
            failures++;
            $display("FAIL ws15_timing got access_cycles=%0d ack_cycle=%0d required 16/17", rd15, ack15);
        end
        checks++;
        if (p0_cpu_rdata !== 16'h5A5A || p15_cpu_rdata !== 16'h5A5A) begin
            failures++;
            $display("FAIL ws_rdata got ws0=%h ws15=%h required 5A5A", p0_cpu_rdata, p15_cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        rd_fixed_en = 1'b1;
        rd_fixed    = 16'h7777;
        cpu_we      = 1'b0;
        cpu_addr    = 12'h0C3;
        cpu_req     = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, busy, grant, cpu_ack} !== 6'b0 || mem_addr !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_async got rd=%b busy=%b grant=%b addr=%h required all zero", mem_rd, busy, grant, mem_addr);
        end
        cpu_req = 1'b0;
        #3;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_ack cycle=%0d got ack=%b busy=%b required 0/0", i, cpu_ack, busy);
            end
        end
        rd_fixed = 16'h4321;
        cpu_req  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({mem_rd, cpu_ack} !== ((c <= 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL post_reset_read cycle=%0d got rd/ack=%b%b", c, mem_rd, cpu_ack);
            end
        end
        checks++;
        if (cpu_rdata !== 16'h4321) begin
            failures++;
            $display("FAIL post_reset_rdata got=%h required=4321", cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_contention();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
